// File: rtl/packed_add_arbiter_if.sv
// Bus bundle between requesters, the packed-add arbiter and its compute unit.
//   req_valid/req_ready : per-requester handshake (ready is a one-hot grant)
//   req_in1/req_in2     : packed 24-bit operands, requester i at [i*24 +: 24]
//   cu_input1/2, cu_out : operands to and 27-bit lane result from the compute unit
//   rsp_valid/rsp_data  : one-hot response id and the result it refers to
//   drain/drained/busy  : quiesce request and status
// slave  : arbiter side
// master : requester/compute-unit side
interface packed_add_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*24-1:0] req_in1;
  logic [NUM_REQ*24-1:0] req_in2;
  logic [23:0]           cu_input1;
  logic [23:0]           cu_input2;
  logic [26:0]           cu_out;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [26:0]           rsp_data;
  logic                  drain;
  logic                  drained;
  logic                  busy;

  modport slave (
    input  req_valid, req_in1, req_in2, cu_out, drain,
    output req_ready, cu_input1, cu_input2, rsp_valid, rsp_data, drained, busy
  );

  modport master (
    output req_valid, req_in1, req_in2, cu_out, drain,
    input  req_ready, cu_input1, cu_input2, rsp_valid, rsp_data, drained, busy
  );
endinterface

// File: rtl/packed_add_arbiter.sv
// Round-robin arbiter sharing one fixed-latency packed-add compute unit among
// NUM_REQ requesters. At most one operation issues per cycle; the requester id
// travels alongside the operation in a CU_LATENCY-deep tag pipeline so the
// result on cu_out can be returned as a one-hot response. A drain handshake
// stops issuing and reports when the pipeline is empty.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high reset (shared with the compute unit)
//   bus   : packed_add_arbiter_if.slave (handshake, operands, results, drain)
module packed_add_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned REQ_ID_W   = 2,
  parameter int unsigned CU_LATENCY = 2
) (
  input logic                 clk,
  input logic                 reset,
  packed_add_arbiter_if.slave bus
);

  localparam logic [NUM_REQ-1:0] OneHot0 = NUM_REQ'(1);

  typedef enum logic [1:0] {StRun, StDrain, StDrained} state_e;

  state_e                state_q, state_d;
  logic [REQ_ID_W-1:0]   ptr_q, ptr_d;
  logic [CU_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [REQ_ID_W-1:0]   tag_id_q [CU_LATENCY];
  logic [REQ_ID_W-1:0]   tag_id_d [CU_LATENCY];

  logic                  grant_en;
  logic                  found;
  logic                  hs;
  logic [REQ_ID_W-1:0]   gnt_id;
  logic [REQ_ID_W-1:0]   scan_id;
  logic                  busy_next;

  // Round-robin search upward from the pointer; the grant is gated in the same
  // cycle drain rises and while reset is held.
  always_comb begin
    grant_en = !reset && (state_q == StRun) && !bus.drain;
    found    = 1'b0;
    gnt_id   = '0;
    scan_id  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_id = REQ_ID_W'((32'(ptr_q) + k) % NUM_REQ);
      if (!found && bus.req_valid[scan_id]) begin
        found  = 1'b1;
        gnt_id = scan_id;
      end
    end
    hs = found && grant_en;
  end

  always_comb begin
    bus.req_ready = hs ? (OneHot0 << gnt_id) : '0;
    bus.cu_input1 = hs ? bus.req_in1[gnt_id*24 +: 24] : '0;
    bus.cu_input2 = hs ? bus.req_in2[gnt_id*24 +: 24] : '0;
  end

  // Pointer and tag pipeline next state.
  always_comb begin
    ptr_d = ptr_q;
    if (hs) begin
      ptr_d = (gnt_id == REQ_ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + REQ_ID_W'(1);
    end
    tag_vld_d    = '0;
    tag_vld_d[0] = hs;
    for (int unsigned j = 0; j < CU_LATENCY; j++) begin
      tag_id_d[j] = '0;
    end
    tag_id_d[0] = gnt_id;
    for (int unsigned j = 1; j < CU_LATENCY; j++) begin
      tag_vld_d[j] = tag_vld_q[j-1];
      tag_id_d[j]  = tag_id_q[j-1];
    end
    // Occupancy as it will be just after this edge.
    busy_next = |tag_vld_d;
  end

  // Drain FSM. Leaving DRAIN looks at post-edge occupancy so DRAINED is reached
  // in the first cycle with nothing in flight.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (bus.drain) state_d = StDrain;
      end
      StDrain: begin
        if (!bus.drain)     state_d = StRun;
        else if (!busy_next) state_d = StDrained;
      end
      StDrained: begin
        if (!bus.drain) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  // Responses from tags issued before a reset are suppressed while it is held.
  always_comb begin
    bus.rsp_valid = (!reset && tag_vld_q[CU_LATENCY-1]) ?
                    (OneHot0 << tag_id_q[CU_LATENCY-1]) : '0;
    bus.rsp_data  = bus.cu_out;
    bus.busy      = !reset && (|tag_vld_q);
    bus.drained   = !reset && (state_q == StDrained);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StRun;
      ptr_q     <= '0;
      tag_vld_q <= '0;
      for (int unsigned j = 0; j < CU_LATENCY; j++) begin
        tag_id_q[j] <= '0;
      end
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      tag_vld_q <= tag_vld_d;
      for (int unsigned j = 0; j < CU_LATENCY; j++) begin
        tag_id_q[j] <= tag_id_d[j];
      end
    end
  end

endmodule

// File: tb/tb_packed_add_arbiter.sv
// Self-checking bench for packed_add_arbiter with a behavioural compute unit.
module tb_packed_add_arbiter;
  localparam int N = 4;
  localparam int L = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  packed_add_arbiter_if #(.NUM_REQ(N)) bus ();

  packed_add_arbiter #(
    .NUM_REQ(N),
    .REQ_ID_W(2),
    .CU_LATENCY(L)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  function automatic logic [26:0] lane_add(input logic [23:0] a, input logic [23:0] b);
    return {9'(a[23:16]) + 9'(b[23:16]), 9'(a[15:8]) + 9'(b[15:8]),
            9'(a[7:0]) + 9'(b[7:0])};
  endfunction

  // Compute unit: two-cycle pipelined lane adder sharing the reset.
  logic [26:0] cu_s1, cu_s2;
  always @(posedge clk) begin
    if (reset) begin
      cu_s1 <= '0;
      cu_s2 <= '0;
    end else begin
      cu_s1 <= lane_add(bus.cu_input1, bus.cu_input2);
      cu_s2 <= cu_s1;
    end
  end
  assign bus.cu_out = cu_s2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Model: expected responses scheduled by absolute cycle number.
  logic [N-1:0] exp_rv [1024] = '{default: '0};
  logic [26:0]  exp_rd [1024] = '{default: '0};
  int m_ptr  = 0;
  int m_mode = 0;  // 0 run, 1 draining, 2 drained

  always @(negedge clk) begin
    int c;
    int g;
    logic [N-1:0] er;
    logic [23:0] e1, e2;
    c = cyc;
    if (reset) begin
      chk("m_rst_ready", 32'(bus.req_ready), 0);
      chk("m_rst_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("m_rst_busy", 32'(bus.busy), 0);
      chk("m_rst_drained", 32'(bus.drained), 0);
      chk("m_rst_cu_input1", 32'(bus.cu_input1), 0);
      for (int k = 0; k < 4; k++) exp_rv[c+k] = '0;
      m_ptr  = 0;
      m_mode = 0;
    end else begin
      g = -1;
      if (m_mode == 0 && !bus.drain) begin
        for (int k = 0; k < N; k++) begin
          if (g < 0 && bus.req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
      end
      er = (g >= 0) ? N'(1 << g) : '0;
      e1 = (g >= 0) ? bus.req_in1[g*24 +: 24] : '0;
      e2 = (g >= 0) ? bus.req_in2[g*24 +: 24] : '0;
      chk("m_ready", 32'(bus.req_ready), 32'(er));
      chk("m_cu_input1", 32'(bus.cu_input1), 32'(e1));
      chk("m_cu_input2", 32'(bus.cu_input2), 32'(e2));
      chk("m_rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv[c]));
      if (exp_rv[c] != '0) chk("m_rsp_data", 32'(bus.rsp_data), 32'(exp_rd[c]));
      chk("m_busy", 32'(bus.busy), 32'(exp_rv[c] != '0 || exp_rv[c+1] != '0));
      chk("m_drained", 32'(bus.drained), 32'(m_mode == 2));
      if (g >= 0) begin
        m_ptr = (g + 1) % N;
        exp_rv[c+L] = er;
        exp_rd[c+L] = lane_add(e1, e2);
      end
      case (m_mode)
        0: if (bus.drain) m_mode = 1;
        1: begin
          if (!bus.drain) m_mode = 0;
          else if (exp_rv[c+1] == '0 && exp_rv[c+2] == '0) m_mode = 2;
        end
        default: if (!bus.drain) m_mode = 0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic d);
    bus.req_valid = v;
    bus.drain     = d;
  endtask

  task automatic set_ops(input int i, input logic [23:0] a, input logic [23:0] b);
    bus.req_in1[i*24 +: 24] = a;
    bus.req_in2[i*24 +: 24] = b;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [26:0] t1_exp, ov_exp;

  initial begin
    t1_exp = {9'h002, 9'h100, 9'h100};
    ov_exp = {9'h1FE, 9'h1FE, 9'h1FE};
    bus.req_valid = '0;
    bus.drain     = 1'b0;
    bus.req_in1   = '0;
    bus.req_in2   = '0;
    reset         = 1'b1;

    // Reset state
    tick();
    @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_drained", 32'(bus.drained), 0);
    do_reset(2);

    // Single request from req0
    set_ops(0, 24'h01FF10, 24'h0101F0);
    drive(4'b0001, 1'b0);
    @(negedge clk);
    chk("t1_grant", 32'(bus.req_ready), 32'h1);
    tick();
    drive(4'b0000, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("t1_rsp_valid", 32'(bus.rsp_valid), (k == 2) ? 32'h1 : 32'h0);
      if (k == 2) chk("t1_rsp_data", 32'(bus.rsp_data), 32'(t1_exp));
      tick();
    end

    // Round-robin fairness with everyone requesting
    do_reset(1);
    for (int i = 0; i < N; i++) begin
      set_ops(i, {8'(i*16 + 1), 8'(i + 8'h80), 8'(8'hF0 + i)},
                 {8'(i + 3), 8'(8'h90 - i), 8'(i*32 + 7)});
    end
    drive(4'hF, 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_grant", 32'(bus.req_ready), 32'(1 << (k % 4)));
      if (k >= 2) chk("rr_rsp_id", 32'(bus.rsp_valid), 32'(1 << ((k - 2) % 4)));
      tick();
    end
    drive(4'h0, 1'b0);
    repeat (3) tick();

    // Sparse requests and pointer wrap
    do_reset(1);
    drive(4'b0100, 1'b0);
    @(negedge clk);
    chk("sp_grant2", 32'(bus.req_ready), 32'b0100);
    tick();
    drive(4'b1010, 1'b0);
    @(negedge clk);
    chk("sp_grant3", 32'(bus.req_ready), 32'b1000);
    tick();
    @(negedge clk);
    chk("sp_grant1", 32'(bus.req_ready), 32'b0010);
    tick();
    drive(4'b0110, 1'b0);
    @(negedge clk);
    chk("sp_ptr2", 32'(bus.req_ready), 32'b0100);
    tick();
    drive(4'h0, 1'b0);
    repeat (3) tick();

    // Drain under continuous requests
    do_reset(1);
    for (int rel = 0; rel <= 16; rel++) begin
      drive(4'hF, (rel >= 10 && rel < 14));
      @(negedge clk);
      if (rel >= 10 && rel <= 14) chk("dr_no_grant", 32'(bus.req_ready), 0);
      if (rel == 10) chk("dr_inflight0", 32'(bus.rsp_valid), 32'b0001);
      if (rel == 11) chk("dr_inflight1", 32'(bus.rsp_valid), 32'b0010);
      if (rel == 12) chk("dr_empty", 32'(bus.rsp_valid), 0);
      if (rel >= 10) chk("dr_drained", 32'(bus.drained), 32'(rel >= 12 && rel <= 14));
      if (rel == 15) chk("dr_resume", 32'(bus.req_ready), 32'b0100);
      tick();
    end
    drive(4'h0, 1'b0);
    repeat (3) tick();

    // Reset while operations are in flight
    do_reset(1);
    for (int rel = 0; rel <= 9; rel++) begin
      reset = (rel == 7);
      drive((rel >= 5 && rel <= 7) ? 4'hF : 4'h0, 1'b0);
      @(negedge clk);
      if (rel >= 7) chk("rf_no_rsp", 32'(bus.rsp_valid), 0);
      if (rel == 7) chk("rf_no_grant", 32'(bus.req_ready), 0);
      if (rel == 7) chk("rf_cu_input", 32'(bus.cu_input1), 0);
      if (rel == 8) chk("rf_busy", 32'(bus.busy), 0);
      tick();
    end
    reset = 1'b0;
    drive(4'hF, 1'b0);
    @(negedge clk);
    chk("rf_ptr0", 32'(bus.req_ready), 32'b0001);
    tick();
    drive(4'h0, 1'b0);
    repeat (3) tick();

    // Lane overflow from req2
    do_reset(1);
    set_ops(2, 24'hFFFFFF, 24'hFFFFFF);
    drive(4'b0100, 1'b0);
    @(negedge clk);
    chk("ov_grant", 32'(bus.req_ready), 32'b0100);
    tick();
    drive(4'h0, 1'b0);
    tick();
    @(negedge clk);
    chk("ov_rsp_valid", 32'(bus.rsp_valid), 32'b0100);
    chk("ov_rsp_data", 32'(bus.rsp_data), 32'(ov_exp));
    repeat (3) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
